digit_scan_ctrl: RTL and testbench

//   Display scan controller that sits directly upstream of the 2-to-4 one-hot decoder.

---
 rtl/digit_scan_ctrl.sv | 75 +++++++
 tb/tb_digit_scan_ctrl.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/digit_scan_ctrl.sv
// Display scan controller: captures the last two received bytes and scans
// them out one hex digit at a time, with a per-digit blank flag.
module digit_scan_ctrl #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int SCAN_HZ = 1_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       clear,
  output logic [1:0] sel,
  output logic [3:0] nibble,
  output logic       blank,
  output logic       scan_tick
);

  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  generate
    if (DIV < 2) begin : g_div_check
      $error("digit_scan_ctrl: CLK_HZ/SCAN_HZ must be >= 2");
    end
  endgenerate

  logic [PW-1:0] pre, pre_n;
  logic [15:0]   disp, disp_n;
  logic [1:0]    byte_cnt, byte_cnt_n;
  logic [1:0]    sel_n;
  logic [3:0]    nibble_n;
  logic          blank_n;
  logic          wrap;

  // nibble/blank are derived from next-state values so they land on the same
  // edge as the sel/disp they describe.
  always_comb begin
    wrap       = (pre == PRE_LAST);
    pre_n      = wrap ? '0 : pre + 1'b1;
    sel_n      = wrap ? sel + 2'd1 : sel;
    disp_n     = disp;
    byte_cnt_n = byte_cnt;
    if (clear) begin
      disp_n     = '0;
      byte_cnt_n = '0;
    end else if (rx_valid) begin
      disp_n = {disp[7:0], rx_data};
      if (byte_cnt != 2'd2) byte_cnt_n = byte_cnt + 2'd1;
    end
    nibble_n = disp_n[{sel_n, 2'b00} +: 4];
    blank_n  = sel_n[1] ? (byte_cnt_n < 2'd2) : (byte_cnt_n == 2'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre       <= '0;
      sel       <= '0;
      disp      <= '0;
      byte_cnt  <= '0;
      scan_tick <= 1'b0;
      nibble    <= '0;
      blank     <= 1'b1;
    end else begin
      pre       <= pre_n;
      sel       <= sel_n;
      disp      <= disp_n;
      byte_cnt  <= byte_cnt_n;
      scan_tick <= wrap;
      nibble    <= nibble_n;
      blank     <= blank_n;
    end
  end

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Scoreboard bench for digit_scan_ctrl: a reference model pushes the expected
// outputs each clock, a monitor pops and compares on the falling edge.
module tb_digit_scan_ctrl;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       clear = 1'b0;
  logic [1:0] sel;
  logic [3:0] nibble;
  logic       blank;
  logic       scan_tick;

  int checks = 0;
  int failures = 0;

  digit_scan_ctrl #(.CLK_HZ(8), .SCAN_HZ(2)) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .clear(clear), .sel(sel), .nibble(nibble), .blank(blank),
    .scan_tick(scan_tick)
  );

  always #5 clk = ~clk;

  // Reference model: edges since reset release, plus the list of kept bytes.
  int         ph = 0;
  logic [7:0] bq[$];
  logic [7:0] expq[$];   // {tick, blank, sel[1:0], nibble[3:0]}

  always @(posedge clk) begin
    logic [15:0] word;
    int s;
    logic bl, tk;
    logic [3:0] nb;
    if (!rst_n) begin
      ph = 0;
      bq.delete();
    end else begin
      ph = ph + 1;
      if (clear) bq.delete();
      else if (rx_valid) begin
        bq.push_back(rx_data);
        if (bq.size() > 2) void'(bq.pop_front());
      end
    end
    word = 16'h0000;
    if (bq.size() >= 1) word[7:0]  = bq[bq.size()-1];
    if (bq.size() >= 2) word[15:8] = bq[bq.size()-2];
    s  = (ph / DIV) % 4;
    nb = 4'((word >> (4 * s)) & 16'h000F);
    bl = (s < 2) ? (bq.size() == 0) : (bq.size() < 2);
    tk = (ph > 0) && (ph % DIV == 0);
    expq.push_back({tk, bl, 2'(s), nb});
  end

  always @(negedge clk) begin
    logic [7:0] e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      checks++;
      if ({scan_tick, blank, sel, nibble} !== e) begin
        failures++;
        $display("FAIL scoreboard t=%0t got tick=%b blank=%b sel=%0d nib=%h want tick=%b blank=%b sel=%0d nib=%h",
                 $time, scan_tick, blank, sel, nibble, e[7], e[6], e[5:4], e[3:0]);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input logic clr);
    rx_valid = 1'b1;
    rx_data  = b;
    clear    = clr;
    @(negedge clk);
    rx_valid = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic wait_phase(input int mod, input int val, input string name);
    int n = 0;
    while ((ph % mod) != val && n < 200) begin
      @(negedge clk);
      n++;
    end
    if ((ph % mod) != val) begin
      checks++;
      failures++;
      $display("FAIL %s timeout ph=%0d want phase %0d", name, ph, val);
    end
  endtask

  initial begin
    idle(3);
    rst_n = 1'b1;
    idle(22);
    send(8'hA5, 1'b0);
    idle(16);
    send(8'h3C, 1'b0);
    idle(16);
    send(8'h71, 1'b0);
    idle(16);
    send(8'hFF, 1'b1);
    idle(16);
    wait_phase(DIV, DIV - 1, "tick_align_a");
    send(8'h5E, 1'b0);
    idle(5);
    wait_phase(DIV, DIV - 1, "tick_align_b");
    send(8'h92, 1'b0);
    idle(12);
    for (int i = 0; i < 400; i++) begin
      rx_valid = ($urandom_range(0, 7) == 0);
      rx_data  = 8'($urandom);
      clear    = ($urandom_range(0, 31) == 0);
      @(negedge clk);
    end
    rx_valid = 1'b0;
    clear    = 1'b0;
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    send(8'hB4, 1'b0);
    send(8'h6D, 1'b0);
    // ph==9: sel=2 with prescaler=1
    wait_phase(1000, 9, "mid_reset_phase");
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (sel !== 2'd0 || blank !== 1'b1 || scan_tick !== 1'b0 || nibble !== 4'h0) begin
      failures++;
      $display("FAIL async_reset got sel=%0d blank=%b tick=%b nib=%h want sel=0 blank=1 tick=0 nib=0",
               sel, blank, scan_tick, nibble);
    end
    idle(2);
    rst_n = 1'b1;
    idle(20);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout at t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule
